// File: rtl/conv5_pkg.sv
// Shared widths, geometry and types for the 5x5 convolution stage.
// Optional bypass path in conv5x5_filter is enabled by defining CONV_BYPASS_EN.
package conv5_pkg;

    localparam int PIX_W      = 8;
    localparam int COEF_W     = 8;
    localparam int KSIZE      = 5;
    localparam int NTAPS      = 25;
    localparam int PROD_W     = 17;
    localparam int ACC_W      = 22;
    localparam int LATENCY    = 7;
    localparam int CENTRE_IDX = 12;

    // One row of five 17b products summed needs three extra bits.
    localparam int PART_W = PROD_W + 3;

    typedef logic signed [COEF_W-1:0] coef_arr_t [NTAPS];
    typedef logic signed [PROD_W-1:0] prod_arr_t [NTAPS];

    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1])
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv5_adder_tree.sv
// Two-level registered adder tree: 25 signed products -> 5 row sums (E5) -> 22b accumulator (E6).
module conv5_adder_tree
    import conv5_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  prod_arr_t               prod,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [PART_W-1:0] part_c [KSIZE];
    logic signed [PART_W-1:0] part_q [KSIZE];
    logic signed [ACC_W-1:0]  acc_c;

    // NOTE: every comb output is given a default before the loop adds into it, so no latch is inferred.
    always_comb begin
        for (int g = 0; g < KSIZE; g++) begin
            part_c[g] = '0;
            for (int i = 0; i < KSIZE; i++)
                part_c[g] = part_c[g] + PART_W'(prod[g*KSIZE + i]);
        end
    end

    always_comb begin
        acc_c = '0;
        for (int g = 0; g < KSIZE; g++)
            acc_c = acc_c + ACC_W'(part_q[g]);
    end

    // NOTE: registered state uses non-blocking assignment so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < KSIZE; g++)
                part_q[g] <= '0;
            acc <= '0;
        end else begin
            part_q <= part_c;
            acc    <= acc_c;
        end
    end

endmodule

// File: rtl/conv5x5_filter.sv
// 5x5 convolution: column-shift window, writable signed kernel, adder tree, scale and saturate.
// Define CONV_BYPASS_EN to add a 'bypass' input that passes the centre tap through at equal latency.
module conv5x5_filter
    import conv5_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pa,
    input  logic [PIX_W-1:0]  pb,
    input  logic [PIX_W-1:0]  pc,
    input  logic [PIX_W-1:0]  pd,
    input  logic [PIX_W-1:0]  pe,
    input  logic              stat_in,
    input  logic              coef_we,
    input  logic [4:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
`ifdef CONV_BYPASS_EN
    input  logic              bypass,
`endif
    output logic [PIX_W-1:0]  pix_o,
    output logic              stat_o
);

    localparam logic signed [COEF_W-1:0] ID_COEF = COEF_W'(1 << SHIFT);
    localparam int CR = CENTRE_IDX / KSIZE;
    localparam int CC = CENTRE_IDX % KSIZE;

    logic [PIX_W-1:0]        win    [KSIZE][KSIZE];  // [row][col], row 0 = pe, col 4 = newest
    logic [PIX_W-1:0]        col_in [KSIZE];
    coef_arr_t               coef;
    prod_arr_t               prod_c;
    prod_arr_t               prod_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] scaled;
    logic [PIX_W-1:0]        pix_next;
    logic [LATENCY-1:0]      stat_sr;

    assign col_in = '{pe, pd, pc, pb, pa};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE; c++)
                    win[r][c] <= '0;
        end else begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE-1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][KSIZE-1] <= col_in[r];
            end
        end
    end

    // NOTE: the coefficient bank is a small register file, not RAM, so it can reset to the identity kernel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++)
                coef[i] <= (i == CENTRE_IDX) ? ID_COEF : '0;
        end else if (coef_we && int'(coef_addr) < NTAPS) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_comb begin
        for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
                prod_c[r*KSIZE + c] = PROD_W'($signed({1'b0, win[r][c]}))
                                    * PROD_W'(coef[r*KSIZE + c]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++)
                prod_q[i] <= '0;
        end else begin
            prod_q <= prod_c;
        end
    end

    conv5_adder_tree u_tree (
        .clk  (clk),
        .rst  (rst),
        .prod (prod_q),
        .acc  (acc)
    );

    assign scaled = acc >>> SHIFT;

`ifdef CONV_BYPASS_EN
    // Centre tap and bypass flag ride alongside E4..E6 so both paths share the same latency.
    logic [PIX_W-1:0] ctr_q [3];
    logic [2:0]       byp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++)
                ctr_q[i] <= '0;
            byp_q <= '0;
        end else begin
            ctr_q[0] <= win[CR][CC];
            ctr_q[1] <= ctr_q[0];
            ctr_q[2] <= ctr_q[1];
            byp_q    <= {byp_q[1:0], bypass};
        end
    end

    assign pix_next = byp_q[2] ? ctr_q[2] : clamp_pix(scaled);
`else
    assign pix_next = clamp_pix(scaled);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_o   <= '0;
            stat_sr <= '0;
        end else begin
            pix_o   <= pix_next;
            stat_sr <= {stat_sr[LATENCY-2:0], stat_in};
        end
    end

    assign stat_o = stat_sr[LATENCY-1];

endmodule
